// File: rtl/seg_scan_if.sv
// Bundle between the datapath and the 7-segment scan driver. The datapath
// side (master) drives the result word and its capture strobe. The
// driver side (slave) drives the display pins and the frame pulse.
interface seg_scan_if;
    logic [31:0] value_in;
    logic        load;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    modport master (
        output value_in,
        output load,
        input  seg,
        input  an,
        input  frame_done
    );

    modport slave (
        input  value_in,
        input  load,
        output seg,
        output an,
        output frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 8-digit hex display driver.
// Words are captured into a shadow register. They are promoted to the
// scanned word only at a frame boundary, so a frame never shows a mix of
// two words. Each digit slot starts with one dark cycle to avoid ghosting.
// Leading zero digits can be suppressed.
module seg_scan_driver #(
    parameter int REFRESH_CYCLES = 50000,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam logic [15:0] LAST_CNT = 16'(REFRESH_CYCLES - 1);

    logic [15:0] cnt_q,    cnt_d;
    logic [2:0]  idx_q,    idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] disp_q,   disp_d;
    logic [6:0]  seg_q,    seg_d;
    logic [7:0]  an_q,     an_d;
    logic        fd_q,     fd_d;

    logic        last_slot_s;
    logic        boundary_s;
    logic [7:0]  blank_s;
    logic [3:0]  nibble_s;

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    // Per-digit leading-zero blank mask. Digit 0 always stays lit, so a
    // zero word still shows a single "0".
    always_comb begin
        blank_s = 8'h00;
        for (int i = 1; i < 8; i++) begin
            if (BLANK_LEADING && ((disp_q >> (4 * i)) == 32'd0)) begin
                blank_s[i] = 1'b1;
            end else begin
                blank_s[i] = 1'b0;
            end
        end
    end

    assign last_slot_s = (cnt_q == LAST_CNT);
    assign boundary_s  = last_slot_s && (idx_q == 3'd7);
    assign nibble_s    = disp_q[{idx_q, 2'b00} +: 4];

    // Next-state logic for scan position, capture path and pin outputs.
    always_comb begin
        cnt_d    = cnt_q + 16'd1;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        fd_d     = 1'b0;
        seg_d    = 7'h7F;
        an_d     = 8'hFF;

        if (last_slot_s) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        if (bus.load) begin
            shadow_d = bus.value_in;
        end else begin
            shadow_d = shadow_q;
        end

        // A load on the boundary edge goes straight into the scanned word.
        if (boundary_s) begin
            disp_d = bus.load ? bus.value_in : shadow_q;
            fd_d   = 1'b1;
        end else begin
            disp_d = disp_q;
            fd_d   = 1'b0;
        end

        if (blank_s[idx_q]) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = hexdec(nibble_s);
        end

        // The first cycle of every slot is dark so the previous digit's
        // segments never bleed into the newly enabled anode.
        if ((cnt_q == 16'd0) || blank_s[idx_q]) begin
            an_d = 8'hFF;
        end else begin
            an_d = ~(8'b1 << idx_q);
        end
    end

    // State and output registers with asynchronous reset to a dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shadow_q <= 32'd0;
            disp_q   <= 32'd0;
            seg_q    <= 7'h7F;
            an_q     <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_CYCLES=4.
// dut0 shows all digits and dut1 suppresses leading zeros. Both receive
// identical stimulus. Outputs are sampled on the falling clock edge.
module tb_seg_scan_driver;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seg_scan_if if0 ();
    seg_scan_if if1 ();

    seg_scan_driver #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    seg_scan_driver #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // 10-unit clock period, first rising edge at t=5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] v, input logic l);
        if0.value_in = v;
        if0.load     = l;
        if1.value_in = v;
        if1.load     = l;
    endtask

    task automatic do_load(input logic [31:0] v);
        drive(v, 1'b1);
        tick();
        drive(32'd0, 1'b0);
    endtask

    function automatic logic [6:0] seg_of(input bit sel);
        return sel ? if1.seg : if0.seg;
    endfunction

    function automatic logic [7:0] an_of(input bit sel);
        return sel ? if1.an : if0.an;
    endfunction

    function automatic logic fd_of(input bit sel);
        return sel ? if1.frame_done : if0.frame_done;
    endfunction

    // Advance until frame_done is seen, bounded to 40 cycles.
    task automatic wait_fd(input bit sel, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd_of(sel) && n < 40);
        chk(tag, 32'(fd_of(sel)), 32'd1);
    endtask

    // Called at the negedge where frame_done is high. Checks the 32 output
    // cycles of the next frame and the following frame_done pulse.
    task automatic check_frame(input bit sel, input logic [55:0] segs,
                               input logic [7:0] mask, input string tag);
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fd;
        for (int d = 0; d < 8; d++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                exp_an  = (j == 0 || mask[d]) ? 8'hFF : ~(8'b1 << d);
                exp_seg = mask[d] ? 7'h7F : segs[7*d +: 7];
                exp_fd  = (d == 7 && j == 3);
                chk($sformatf("%s_an_d%0d_c%0d", tag, d, j), 32'(an_of(sel)), 32'(exp_an));
                chk($sformatf("%s_seg_d%0d_c%0d", tag, d, j), 32'(seg_of(sel)), 32'(exp_seg));
                chk($sformatf("%s_fd_d%0d_c%0d", tag, d, j), 32'(fd_of(sel)), 32'(exp_fd));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(32'd0, 1'b0);

        // Power-up reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("por_seg0", 32'(if0.seg), 32'h7F);
        chk("por_an0", 32'(if0.an), 32'hFF);
        chk("por_fd0", 32'(if0.frame_done), 32'h0);
        chk("por_an1", 32'(if1.an), 32'hFF);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: reach idx=5 (cnt=2), then reset asynchronously.
        repeat (22) tick();
        chk("t1_pre_an0", 32'(if0.an), 32'hDF);
        chk("t1_pre_seg0", 32'(if0.seg), 32'h40);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_seg0", 32'(if0.seg), 32'h7F);
        chk("t1_rst_an0", 32'(if0.an), 32'hFF);
        chk("t1_rst_fd0", 32'(if0.frame_done), 32'h0);
        chk("t1_rst_seg1", 32'(if1.seg), 32'h7F);
        chk("t1_rst_an1", 32'(if1.an), 32'hFF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t1_ghost_d0", 32'(if0.an), 32'hFF);
        tick();
        chk("t1_lit_an_d0", 32'(if0.an), 32'hFE);
        chk("t1_lit_seg_d0", 32'(if0.seg), 32'h40);
        repeat (3) tick();
        chk("t1_ghost_d1", 32'(if0.an), 32'hFF);
        tick();
        chk("t1_lit_an_d1", 32'(if0.an), 32'hFD);

        // Test 2: full hex word, no suppression.
        do_load(32'h89ABCDEF);
        wait_fd(1'b0, "t2_wait");
        check_frame(1'b0, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    8'h00, "t2");

        // Test 3: leading-zero suppression.
        do_load(32'h00000000);
        wait_fd(1'b1, "t3a_wait");
        check_frame(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                    8'hFE, "t3a");
        do_load(32'h00000300);
        wait_fd(1'b1, "t3b_wait");
        check_frame(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40},
                    8'hF8, "t3b");

        // Test 4: a mid-frame load must not tear the current frame.
        do_load(32'h11111111);
        wait_fd(1'b1, "t4_wait1");
        repeat (13) tick();
        do_load(32'h22222222);
        chk("t4_d3_seg", 32'(if1.seg), 32'h79);
        chk("t4_d3_an", 32'(if1.an), 32'hF7);
        repeat (4) tick();
        chk("t4_d4_seg", 32'(if1.seg), 32'h79);
        chk("t4_d4_an", 32'(if1.an), 32'hEF);
        repeat (12) tick();
        chk("t4_d7_seg", 32'(if1.seg), 32'h79);
        chk("t4_d7_an", 32'(if1.an), 32'h7F);
        wait_fd(1'b1, "t4_wait2");
        check_frame(1'b1, {7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24},
                    8'h00, "t4");

        // Test 5: load exactly on the boundary edge (cnt=3, idx=7).
        repeat (31) tick();
        chk("t5_pre_fd", 32'(if1.frame_done), 32'h0);
        do_load(32'h00000005);
        chk("t5_fd", 32'(if1.frame_done), 32'h1);
        check_frame(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12},
                    8'hFE, "t5");

        // Test 6: back-to-back loads, the last one wins.
        drive(32'h0000000A, 1'b1);
        tick();
        drive(32'h0000000B, 1'b1);
        tick();
        drive(32'h0000000C, 1'b1);
        tick();
        drive(32'd0, 1'b0);
        wait_fd(1'b1, "t6_wait");
        check_frame(1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46},
                    8'hFE, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Downstream display stage for the single-cycle CPU. It consumes a 32-bit result word from the datapath and shows it as 8 hex digits on a multiplexed, common-anode 7-segment display. A strobe captures the word into a shadow register. The word is promoted to the scanned display only at a frame boundary, so the display never tears. Scanning uses a refresh counter, a digit index, a per-digit ghosting blank and leading-zero suppression.

Parameters:
REFRESH_CYCLES, 50000, clk cycles per digit slot; legal range 2..65535.
BLANK_LEADING, 1, 1 = suppress leading zero digits; 0 = always show all 8 digits.

Ports:
rst  input  1  asynchronous reset, active-high
clk  input  1  system clock (same clock the CPU core runs on)
value_in  input  32  word to display; digit 0 = value_in[3:0] (rightmost)
load  input  1  capture strobe; value_in is sampled on any rising clk edge with load=1
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
an  output  8  digit enables, active-low; an[i] drives digit i
frame_done  output  1  one-cycle pulse when the digit index wraps 7->0

Behaviour:
- Reset (async, rst=1) forces the following values immediately, independent of clk:
  - refresh counter cnt=0, digit index idx=0
  - shadow=0, disp=0
  - seg=7'h7F, an=8'hFF, frame_done=0
- Reset mid-frame aborts the scan. After rst deasserts, the scan restarts at idx=0, cnt=0.
- Capture:
  - On a clk edge with load=1: shadow <= value_in.
  - Back-to-back loads: the last one wins.
- Refresh counter:
  - cnt increments each clk.
  - At cnt==REFRESH_CYCLES-1, cnt <= 0 and idx <= idx+1 mod 8.
- Frame boundary: the edge where cnt==REFRESH_CYCLES-1 and idx==7. On that edge:
  - disp <= (load ? value_in : shadow). A load on the boundary edge is bypassed straight into disp.
  - frame_done <= 1 for exactly one cycle; 0 otherwise.
- Blanking of digit i (combinational, on disp):
  - Digit i is blank when BLANK_LEADING=1, i>0, and disp[31:4i]==0.
  - Digit 0 is never blank, so a value of 0 shows a single "0".
- Registered outputs, computed from the current (cnt, idx, disp), so they appear one cycle after the state:
  - an_next = 8'hFF if cnt==0 (ghosting blank) or digit idx is blank; otherwise ~(8'b1 << idx).
  - seg_next = 7'h7F if digit idx is blank; otherwise hexdec(disp[4idx+3:4idx]).
- hexdec, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex)
- Frame period is exactly 8*REFRESH_CYCLES cycles. At most one an bit is low at any time.
- Latency:
  - load to shadow: 1 edge.
  - shadow to disp: at the next frame boundary, worst case 8*REFRESH_CYCLES cycles.
  - disp to pins: 1 cycle.
- cnt is wide enough for REFRESH_CYCLES-1 with no overflow: 16 bits.

Test Plan:
1. REFRESH_CYCLES=4. Assert rst mid-slot with idx=5 -> seg=7F, an=FF, frame_done=0 immediately with no clk edge; after release, first digit-0 slot starts at cnt=0.
2. REFRESH_CYCLES=4, BLANK_LEADING=0. Pulse load with value_in=32'h89ABCDEF, let one frame pass -> next frame, per digit 0..7: seg=0E,06,21,46,03,08,10,00. In each slot an is FF on the first output cycle, then the correct single-low pattern for 3 cycles.
3. BLANK_LEADING=1. Load 32'h00000000 -> only digit 0 lit, seg=40, an=FE; an=FF in slots 1-7. Load 32'h00000300 -> digits 0..2 show 0,0,3 (40,40,30); digits 3-7 dark.
4. Tearing: load 32'h11111111, wait for frame_done, then load 32'h22222222 while idx=3 -> remaining digits of the current frame still show "1" (79). Every digit of the next frame shows "2" (24).
5. Boundary bypass: assert load with value_in=32'h5 on the exact edge where cnt=3, idx=7 -> next frame shows 5 (seg=12) on digit 0. frame_done is high for exactly 1 cycle. Frame_done pulses are spaced 32 cycles apart.
6. Back-to-back loads of 32'hA, 32'hB, 32'hC on consecutive cycles within one frame -> next frame digit 0 shows C (seg=46).
